// File: rtl/ram_mmio.sv
// ram_mmio: a single-port word RAM with memory-mapped output registers and
// synchronised input ports, all behind one address/data access interface.
// After reset the RAM is swept to zero, one word per cycle, and BUSY is held
// during the sweep. Reads are registered (one cycle of latency). Accesses to
// addresses outside the map set a sticky error flag.
module ram_mmio #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int N_OUT   = 2,
    parameter int N_IN    = 2,
    parameter int IO_BASE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDR_W-1:0]       ADDR,
    input  logic [DATA_W-1:0]       WDATA,
    input  logic                    WEN,
    input  logic                    REN,
    output logic [DATA_W-1:0]       RDATA,
    output logic                    RVALID,
    output logic                    BUSY,
    input  logic [N_IN*DATA_W-1:0]  IO_IN,
    output logic [N_OUT*DATA_W-1:0] IO_OUT,
    output logic [N_OUT-1:0]        IO_OUT_STB,
    output logic                    ADDR_ERR,
    input  logic                    ERR_CLR
);

    // ------------------------------------------------------------------
    // Derived constants. Address limits are held one bit wider than ADDR
    // so that IO_BASE+N_OUT+N_IN == 2^ADDR_W is still representable.
    // ------------------------------------------------------------------
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IN_BASE_I = IO_BASE + N_OUT;
    localparam int IN_END_I  = IN_BASE_I + N_IN;

    localparam logic [ADDR_W:0]  RAM_END  = DEPTH[ADDR_W:0];
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Reject illegal parameter sets at elaboration.
    if (DEPTH < 2 || IO_BASE < DEPTH || N_OUT < 1 || N_IN < 1 ||
        IN_END_I > (1 << ADDR_W)) begin : g_param_err
        $error("ram_mmio: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy;

    // State and sweep pointer registers; reset restarts the sweep at word 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: walk ptr through every RAM word, then go READY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                busy = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Accesses only count once the sweep has finished.
    logic ready;
    logic rd_en;
    logic wr_en;
    logic clr_en;

    assign ready  = (state_q == ST_READY);
    assign rd_en  = REN & ready;
    assign wr_en  = WEN & ready;
    assign clr_en = ERR_CLR & ready;

    // ------------------------------------------------------------------
    // Address decode at full width: anything >= DEPTH never aliases into
    // the RAM because the upper address bits take part in the compare.
    // ------------------------------------------------------------------
    logic [ADDR_W:0]   addr_x;
    logic              ram_hit;
    logic [N_OUT-1:0]  out_hit;
    logic [N_IN-1:0]   in_hit;
    logic              mapped;

    assign addr_x  = {1'b0, ADDR};
    assign ram_hit = (addr_x < RAM_END);
    assign mapped  = ram_hit | (|out_hit) | (|in_hit);

    // Read data contributions from the IO side; each term is zero unless
    // its own address is selected, so they can simply be OR-ed together.
    logic [DATA_W-1:0] out_term [N_OUT];
    logic [DATA_W-1:0] in_term  [N_IN];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        localparam int              OA_I = IO_BASE + gi;
        localparam logic [ADDR_W:0] OA   = OA_I[ADDR_W:0];

        logic [DATA_W-1:0] out_q;

        assign out_hit[gi] = (addr_x == OA);
        assign out_term[gi] = out_hit[gi] ? out_q : '0;
        assign IO_OUT[gi*DATA_W +: DATA_W] = out_q;

        // Output register j loads WDATA on a qualified write to its address.
        always_ff @(posedge CLK) begin
            if (RST) begin
                out_q <= '0;
            end else if (wr_en && out_hit[gi]) begin
                out_q <= WDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input ports, each behind a two-flop synchroniser
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
        localparam int              IA_I = IN_BASE_I + gi;
        localparam logic [ADDR_W:0] IA   = IA_I[ADDR_W:0];

        logic [DATA_W-1:0] sync1_q;
        logic [DATA_W-1:0] sync2_q;

        assign in_hit[gi]  = (addr_x == IA);
        assign in_term[gi] = in_hit[gi] ? sync2_q : '0;

        // Two-stage synchroniser; software only ever sees the second stage.
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= IO_IN[gi*DATA_W +: DATA_W];
                sync2_q <= sync1_q;
            end
        end
    end

    // Merge the IO read sources; unmapped and RAM addresses give zero here.
    logic [DATA_W-1:0] io_rd_d;

    always_comb begin
        io_rd_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            io_rd_d = io_rd_d | out_term[j];
        end
        for (int k = 0; k < N_IN; k++) begin
            io_rd_d = io_rd_d | in_term[k];
        end
    end

    // ------------------------------------------------------------------
    // RAM: one write port (shared between sweep and user writes) and one
    // registered read port. The read and write in the same edge naturally
    // give read-before-write because both are non-blocking.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;
    logic              ram_we;
    logic [PTR_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [PTR_W-1:0]  ram_raddr;

    // Select the write source: zero from the sweep, or user data when ready.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ADDR[PTR_W-1:0];
        ram_wdata = WDATA;
        if (busy) begin
            ram_we    = ~RST;
            ram_waddr = ptr_q;
            ram_wdata = '0;
        end else if (wr_en && ram_hit) begin
            ram_we = ~RST;
        end
    end

    assign ram_re    = rd_en & ram_hit & ~RST;
    assign ram_raddr = ADDR[PTR_W-1:0];

    // Block RAM body: synchronous write, registered read.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_rd_q <= mem_q[ram_raddr];
        end
    end

    // ------------------------------------------------------------------
    // Read response, strobes and the sticky error flag
    // ------------------------------------------------------------------
    logic              rvalid_q;
    logic              rsel_ram_q;
    logic [DATA_W-1:0] io_rd_q;
    logic [N_OUT-1:0]  stb_q, stb_d;
    logic              err_q, err_d;

    assign stb_d = out_hit & {N_OUT{wr_en}};
    // A new unmapped access wins over a coincident clear.
    assign err_d = (err_q & ~clr_en) | ((rd_en | wr_en) & ~mapped);

    // Response registers; the source select only moves on a real read so
    // RDATA keeps its last value between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q   <= 1'b0;
            rsel_ram_q <= 1'b0;
            io_rd_q    <= '0;
            stb_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            stb_q    <= stb_d;
            err_q    <= err_d;
            if (rd_en) begin
                rsel_ram_q <= ram_hit;
                io_rd_q    <= io_rd_d;
            end
        end
    end

    assign RDATA      = rsel_ram_q ? ram_rd_q : io_rd_q;
    assign RVALID     = rvalid_q;
    assign BUSY       = busy;
    assign IO_OUT_STB = stb_q;
    assign ADDR_ERR   = err_q;

endmodule

// File: tb/tb_ram_mmio.sv
// Directed testbench for ram_mmio with default parameters.
module tb_ram_mmio;

    logic        CLK;
    logic        RST;
    logic [7:0]  ADDR;
    logic [15:0] WDATA;
    logic        WEN;
    logic        REN;
    logic [15:0] RDATA;
    logic        RVALID;
    logic        BUSY;
    logic [31:0] IO_IN;
    logic [31:0] IO_OUT;
    logic [1:0]  IO_OUT_STB;
    logic        ADDR_ERR;
    logic        ERR_CLR;

    int n_checks = 0;
    int n_pass   = 0;

    ram_mmio dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .WEN        (WEN),
        .REN        (REN),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .BUSY       (BUSY),
        .IO_IN      (IO_IN),
        .IO_OUT     (IO_OUT),
        .IO_OUT_STB (IO_OUT_STB),
        .ADDR_ERR   (ADDR_ERR),
        .ERR_CLR    (ERR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WEN     = 1'b0;
        REN     = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        ADDR  = a;
        WDATA = d;
        WEN   = 1'b1;
        tick();
        WEN   = 1'b0;
        $display("[%0t] write addr=%0d data=0x%04h", $time, a, d);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
        ADDR = a;
        REN  = 1'b1;
        tick();
        REN  = 1'b0;
        $display("[%0t] read  addr=%0d data=0x%04h valid=%0b", $time, a, RDATA, RVALID);
        check(tag, {15'b0, RVALID, RDATA}, {15'b0, 1'b1, exp});
    endtask

    // Count cycles until BUSY drops, bounded so the bench cannot hang.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (BUSY && cnt < 200) begin
            tick();
            cnt++;
        end
        $display("[%0t] sweep done after %0d cycles", $time, cnt);
    endtask

    initial begin
        int  cnt;
        logic saw_rv, saw_err, saw_stb;

        RST = 1'b1; ADDR = '0; WDATA = '0; IO_IN = '0;
        idle();
        tick();
        tick();
        check("rst_rdata",  {16'b0, RDATA}, 32'h0);
        check("rst_rvalid", {31'b0, RVALID}, 32'h0);
        check("rst_ioout",  IO_OUT, 32'h0);
        check("rst_stb",    {30'b0, IO_OUT_STB}, 32'h0);
        check("rst_err",    {31'b0, ADDR_ERR}, 32'h0);
        check("rst_busy",   {31'b0, BUSY}, 32'h1);

        // Sweep with accesses attempted throughout; all must be ignored.
        RST = 1'b0;
        WEN = 1'b1; REN = 1'b1; ERR_CLR = 1'b1; WDATA = 16'hFFFF;
        saw_rv = 0; saw_err = 0; saw_stb = 0; cnt = 0;
        while (BUSY && cnt < 200) begin
            ADDR = cnt[0] ? 8'd200 : 8'd65;
            tick();
            cnt++;
            saw_rv  |= RVALID;
            saw_err |= ADDR_ERR;
            saw_stb |= |IO_OUT_STB;
        end
        idle();
        $display("[%0t] sweep done after %0d cycles", $time, cnt);
        check("sweep_len",   cnt, 64);
        check("busy_rvalid", {31'b0, saw_rv}, 32'h0);
        check("busy_err",    {31'b0, saw_err}, 32'h0);
        check("busy_stb",    {31'b0, saw_stb}, 32'h0);
        check("busy_ioout",  IO_OUT, 32'h0);

        // Back-to-back reads of the whole RAM: every cycle valid, all zero.
        REN = 1'b1;
        for (int a = 0; a < 64; a++) begin
            ADDR = 8'(a);
            tick();
            check($sformatf("clr_rd_%0d", a), {15'b0, RVALID, RDATA}, {15'b0, 1'b1, 16'h0});
        end
        REN = 1'b0;
        $display("[%0t] burst read 0..63 done", $time);
        tick();
        check("rvalid_drop", {31'b0, RVALID}, 32'h0);

        // RAM write/read and read-before-write on a collision.
        do_write(8'd5, 16'hBEEF);
        do_read("ram_rd5", 8'd5, 16'hBEEF);
        ADDR = 8'd5; WDATA = 16'h1234; WEN = 1'b1; REN = 1'b1;
        tick();
        idle();
        $display("[%0t] write+read addr=5 data=0x%04h", $time, RDATA);
        check("ram_rbw", {15'b0, RVALID, RDATA}, {15'b0, 1'b1, 16'hBEEF});
        do_read("ram_rd5_new", 8'd5, 16'h1234);
        tick();
        check("rdata_hold", {15'b0, RVALID, RDATA}, {15'b0, 1'b0, 16'h1234});

        // Output registers and strobes.
        do_write(8'd65, 16'h00A5);
        check("out1_val", IO_OUT, 32'h00A5_0000);
        check("out1_stb", {30'b0, IO_OUT_STB}, 32'h2);
        tick();
        check("out1_stb_end", {30'b0, IO_OUT_STB}, 32'h0);
        do_write(8'd64, 16'h1111);
        check("out0_val", IO_OUT, 32'h00A5_1111);
        check("out0_stb", {30'b0, IO_OUT_STB}, 32'h1);
        do_read("out1_rd", 8'd65, 16'h00A5);
        do_read("out0_rd", 8'd64, 16'h1111);

        // Input synchroniser latency.
        IO_IN[15:0] = 16'h5A5A;
        tick();
        ADDR = 8'd66; REN = 1'b1;
        tick();
        check("in0_early", {15'b0, RVALID, RDATA}, {15'b0, 1'b1, 16'h0});
        tick();
        REN = 1'b0;
        $display("[%0t] read  addr=66 data=0x%04h (after sync)", $time, RDATA);
        check("in0_sync", {15'b0, RVALID, RDATA}, {15'b0, 1'b1, 16'h5A5A});
        IO_IN[31:16] = 16'h1357;
        tick(); tick(); tick();
        do_read("in1_rd", 8'd67, 16'h1357);
        do_write(8'd66, 16'hFFFF);
        check("in_wr_noerr", {31'b0, ADDR_ERR}, 32'h0);
        do_read("in0_after_wr", 8'd66, 16'h5A5A);

        // Unmapped accesses and the sticky error flag.
        do_read("unm_rd", 8'd200, 16'h0000);
        check("unm_rd_err", {31'b0, ADDR_ERR}, 32'h1);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        check("errclr1", {31'b0, ADDR_ERR}, 32'h0);
        do_write(8'd70, 16'hFFFF);
        check("unm_wr_err", {31'b0, ADDR_ERR}, 32'h1);
        check("unm_wr_stb", {30'b0, IO_OUT_STB}, 32'h0);
        check("unm_wr_out", IO_OUT, 32'h00A5_1111);
        do_read("no_alias6", 8'd6, 16'h0000);
        do_read("ram5_kept", 8'd5, 16'h1234);
        ADDR = 8'd255; REN = 1'b1; ERR_CLR = 1'b1;
        tick();
        idle();
        $display("[%0t] read  addr=255 with ERR_CLR", $time);
        check("set_wins", {31'b0, ADDR_ERR}, 32'h1);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        check("errclr2", {31'b0, ADDR_ERR}, 32'h0);

        // Reset in READY with an access pending at the reset edge.
        do_write(8'd10, 16'hFFFF);
        do_write(8'd64, 16'h0001);
        do_read("unm_pre_rst", 8'd201, 16'h0000);
        RST = 1'b1; ADDR = 8'd65; WDATA = 16'h4321; WEN = 1'b1; REN = 1'b1;
        tick();
        idle();
        $display("[%0t] reset with pending access", $time);
        check("rst2_rvalid", {31'b0, RVALID}, 32'h0);
        check("rst2_stb",    {30'b0, IO_OUT_STB}, 32'h0);
        check("rst2_ioout",  IO_OUT, 32'h0);
        check("rst2_err",    {31'b0, ADDR_ERR}, 32'h0);
        check("rst2_busy",   {31'b0, BUSY}, 32'h1);

        // Re-assert reset 30 cycles into the sweep; it must restart fully.
        RST = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_busy", {31'b0, BUSY}, 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        wait_ready(cnt);
        check("sweep_len2", cnt, 64);
        do_read("ram10_clr", 8'd10, 16'h0000);
        do_read("ram5_clr",  8'd5,  16'h0000);
        do_read("out1_rst",  8'd65, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_mmio.md
RAM_MMIO -- requirements
Module: ram_mmio

Interface
REQ-001 The module SHALL have these parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, address width.
- DEPTH, 64, RAM words.
- N_OUT, 2, memory-mapped output registers.
- N_IN, 2, memory-mapped input ports.
- IO_BASE, 64, first IO address.

REQ-002 Parameter legality SHALL be DEPTH >= 2, IO_BASE >= DEPTH, and IO_BASE+N_OUT+N_IN <= 2^ADDR_W, with N_OUT >= 1 and N_IN >= 1.

REQ-003 The module SHALL have these ports (clock and reset first):
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADDR  in  ADDR_W  access address.
- WDATA  in  DATA_W  write data.
- WEN  in  1  write request.
- REN  in  1  read request.
- RDATA  out  DATA_W  read data.
- RVALID  out  1  RDATA valid pulse.
- BUSY  out  1  clear sweep in progress; accesses ignored.
- IO_IN  in  N_IN*DATA_W  input ports; port k occupies bits [k*DATA_W +: DATA_W].
- IO_OUT  out  N_OUT*DATA_W  output registers; same packing as IO_IN.
- IO_OUT_STB  out  N_OUT  one-cycle pulse per written output register.
- ADDR_ERR  out  1  sticky unmapped-access flag.
- ERR_CLR  in  1  clears ADDR_ERR.

Function
REQ-004 The address map SHALL be:
- RAM: 0..DEPTH-1.
- Output register j: IO_BASE+j (read/write).
- Input port k: IO_BASE+N_OUT+k (read-only).
- All other addresses: unmapped.

REQ-005 The FSM SHALL have two states, CLEAR and READY; RST SHALL force CLEAR with the sweep pointer at 0.

REQ-006 In CLEAR, the block SHALL write 0 to RAM[ptr] each cycle and increment ptr; on the cycle ptr==DEPTH-1 it SHALL transition to READY, so BUSY is high for exactly DEPTH cycles after RST deasserts.

REQ-007 BUSY SHALL be 1 in CLEAR and 0 in READY.

REQ-008 WEN, REN and ERR_CLR SHALL be ignored while BUSY=1: no writes, no RVALID, no STB, no ADDR_ERR change.

REQ-009 Reads SHALL have latency 1: REN=1 sampled at edge t yields RVALID=1 for exactly one cycle after edge t+1, with RDATA holding the addressed value.

REQ-010 RDATA SHALL hold its last value while RVALID=0.

REQ-011 Back-to-back REN cycles SHALL produce back-to-back RVALID cycles with no bubbles.

REQ-012 RAM writes SHALL take effect at the edge where WEN=1 is sampled.

REQ-013 When WEN=1 and REN=1 hit the same RAM address in one cycle, the read SHALL return the pre-write data (read-before-write).

REQ-014 A write to output register j SHALL update IO_OUT slice j at that edge and pulse IO_OUT_STB[j] for the following cycle.

REQ-015 A read of output register j SHALL return its current value.

REQ-016 Each IO_IN slice SHALL pass through a two-flop synchroniser; reads of input port k SHALL return the second-stage flop, so a change on IO_IN is visible to a read issued 2 or more cycles later.

REQ-017 Writes to input-port addresses SHALL be ignored and SHALL NOT set ADDR_ERR.

REQ-018 An unmapped read SHALL return RDATA=0 with RVALID=1 and set ADDR_ERR.

REQ-019 An unmapped write SHALL be discarded and SHALL set ADDR_ERR.

REQ-020 ADDR_ERR SHALL stay set until ERR_CLR=1; if a new unmapped access and ERR_CLR=1 coincide, ADDR_ERR SHALL end at 1 (set wins).

REQ-021 Address comparison SHALL be unsigned at full ADDR_W width with no aliasing or wrap-around of addresses >= DEPTH into RAM.

Reset
REQ-022 On RST=1 at an edge, outputs SHALL become:
- RDATA=0, RVALID=0, IO_OUT=0, IO_OUT_STB=0, ADDR_ERR=0.
- BUSY=1, synchroniser flops=0.

REQ-023 RST asserted mid-sweep SHALL restart the sweep at ptr=0.

REQ-024 RST asserted in READY SHALL re-enter CLEAR, and RAM SHALL read all-zero once BUSY falls.

REQ-025 An access pending at the RST edge SHALL be dropped: no RVALID, no STB.

Verification
REQ-026 Clear sweep: release RST with default parameters -> BUSY high exactly 64 cycles; afterwards REN of addresses 0..63 -> RDATA=0 for each.

REQ-027 RAM access: write 0xBEEF to address 5, then next cycle REN address 5 -> RVALID one cycle later with RDATA=0xBEEF; simultaneous WEN 0x1234 + REN at address 5 -> RDATA=0xBEEF, and a subsequent read -> 0x1234.

REQ-028 Output port: write 0x00A5 to address 65 -> IO_OUT[31:16]=0x00A5, IO_OUT_STB=2'b10 for one cycle; readback of 65 -> 0x00A5.

REQ-029 Input sync: set IO_IN[15:0]=0x5A5A, then REN address 66 on the next cycle -> 0; REN issued 2 cycles after the change -> 0x5A5A.

REQ-030 Unmapped and error:
- REN address 200 -> RDATA=0, RVALID=1, ADDR_ERR=1.
- WEN address 70 -> no state change.
- ERR_CLR together with a new unmapped access -> ADDR_ERR stays 1.
- ERR_CLR alone -> ADDR_ERR=0.

REQ-031 Reset mid-operation: assert RST at sweep cycle 30 -> BUSY stays high 64 further cycles; RST in READY after writing 0xFFFF at address 10 and 0x1 at address 64 -> IO_OUT=0, and address 10 reads 0 once BUSY falls.
